uart_tx_mmio: RTL

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_tx_mmio.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter with a byte FIFO.
// Register window: TXDATA (+0), STATUS (+4), DIVISOR (+8), reserved (+12).
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit (8E1 frame).
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h0030_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemdatain,
  input  logic [2:0]  dmemop,
  input  logic        dmemwe,
  output logic        hit,
  output logic [31:0] dmemdataout,
  output logic        txd,
  output logic        irq
);

  // state    | meaning
  // IDLE     | line high, waiting for a queued byte
  // START    | start bit (low)
  // DATA     | 8 data bits, LSB first
  // PARITY   | even-parity bit (only reachable with UART_TX_PARITY_EN)
  // STOP     | stop bit (high); pops the next byte directly if one is queued
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  state_t          state;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;
  logic            overflow;
  logic [15:0]     divisor;
  logic [15:0]     bit_cnt;
  logic [15:0]     div_reload;
  logic [7:0]      shreg;
  logic [2:0]      bit_idx;
  logic [1:0]      offset;
  logic [6:0]      count_ext;
  logic            full, empty, busy, pop, push, bit_done;
  logic            wr_txdata, wr_status, wr_divisor;
  logic            unused_inputs;

  assign hit        = (dmemaddr[31:4] == BASE_ADDR[31:4]);
  assign offset     = dmemaddr[3:2];
  assign wr_txdata  = hit && dmemwe && (offset == 2'd0);
  assign wr_status  = hit && dmemwe && (offset == 2'd1);
  assign wr_divisor = hit && dmemwe && (offset == 2'd2);

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign busy       = (state != IDLE);
  assign irq        = empty && !busy;
  assign count_ext  = 7'(count);

  // A divisor of 0 behaves as 1: the down-counter reloads with divisor-1, floored at 0.
  assign div_reload = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
  assign bit_done   = (bit_cnt == 16'd0);

  // Pop happens when idle, or at the end of a stop bit so frames run back to back.
  assign pop  = !empty && ((state == IDLE) || (state == STOP && bit_done));
  // A write to a full FIFO is still accepted if a slot frees up on the same edge.
  assign push = wr_txdata && (!full || pop);

  // Access size and sub-word address bits do not matter to this block.
  assign unused_inputs = ^{dmemop, dmemaddr[1:0], dmemdatain[31:16]};

  // FIFO storage; no reset needed since pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= dmemdatain[7:0];
  end

  // FIFO pointers, occupancy count and the sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (wr_status)
        overflow <= 1'b0;
      else if (wr_txdata && full && !pop)
        overflow <= 1'b1;
    end
  end

  // Baud divisor register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) divisor <= DEFAULT_DIV;
    else if (wr_divisor) divisor <= dmemdatain[15:0];
  end

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  // Even parity of the byte being framed, captured when it is popped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) parity_bit <= 1'b0;
    else if (pop) parity_bit <= ^fifo_mem[rd_ptr];
  end
`endif

  // Transmit FSM; the bit timer reloads at every bit boundary from the live divisor.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      txd     <= 1'b1;
      bit_cnt <= 16'd0;
      shreg   <= 8'd0;
      bit_idx <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= START;
            txd     <= 1'b0;
            shreg   <= fifo_mem[rd_ptr];
            bit_cnt <= div_reload;
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= 3'd0;
            bit_cnt <= div_reload;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt <= div_reload;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd   <= parity_bit;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        PARITY: begin
          if (bit_done) begin
            state   <= STOP;
            txd     <= 1'b1;
            bit_cnt <= div_reload;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            bit_cnt <= div_reload;
            if (pop) begin
              state <= START;
              txd   <= 1'b0;
              shreg <= fifo_mem[rd_ptr];
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  // Combinational register read mux; reads never change state.
  always_comb begin
    dmemdataout = 32'd0;
    if (hit) begin
      case (offset)
        2'd1:    dmemdataout = {21'd0, count_ext, overflow, busy, empty, full};
        2'd2:    dmemdataout = {16'd0, divisor};
        default: dmemdataout = 32'd0;
      endcase
    end
  end

endmodule
